// File: rtl/cla16_wide_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla16_wide_add_seq_pkg
// Shared definitions for the wide add/subtract sequencer:
//   slice_w     width of one adder slice (the external cla16 is 16 bits wide)
//   state_e     sequencer FSM states (idle / run / done)
//   idx_width   width of the slice index for a given number of slices
// ---------------------------------------------------------------------------
package cla16_wide_add_seq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Slice index width; never narrower than one bit.
   function automatic int idx_width(input int words);
      if (words > 2) begin
         return $clog2(words);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/cla16_wide_add_seq_if.sv
// ---------------------------------------------------------------------------
// cla16_wide_add_seq_if
// Bundles the operand request channel, the result channel and the link to the
// external 16-bit cla16 adder.
//   in_*   : operand request (valid/ready, a, b, cin, sub)
//   add_*  : slice operands to cla16 and its sum / carry-out back
//   out_*  : result (valid/ready, sum, cout)
// Modports: slave  = the sequencer itself
//           master = the environment (requester, consumer and cla16)
// ---------------------------------------------------------------------------
interface cla16_wide_add_seq_if #(
   parameter int WORDS = 4
);
   import cla16_wide_add_seq_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   logic [SLICE_W*WORDS-1:0]   in_a;
   logic [SLICE_W*WORDS-1:0]   in_b;
   logic                       in_cin;
   logic                       in_sub;

   logic [SLICE_W-1:0]         add_a;
   logic [SLICE_W-1:0]         add_b;
   logic                       add_cin;
   logic [SLICE_W-1:0]         add_sum;
   logic                       add_cout;

   logic                       out_valid;
   logic                       out_ready;
   logic [SLICE_W*WORDS-1:0]   out_sum;
   logic                       out_cout;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub,
      output in_ready,
      output add_a, add_b, add_cin,
      input  add_sum, add_cout,
      output out_valid, out_sum, out_cout,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub,
      input  in_ready,
      input  add_a, add_b, add_cin,
      output add_sum, add_cout,
      input  out_valid, out_sum, out_cout,
      output out_ready
   );

endinterface

// File: rtl/cla16_slice_mux.sv
// ---------------------------------------------------------------------------
// cla16_slice_mux
// Selects 16-bit slice number idx out of a WORDS*16-bit vector.
//   vec    in   WORDS*16   wide source vector
//   idx    in   IDX_W      slice number (0 = least significant)
//   slice  out  16         selected slice, zero for an index past the end
// ---------------------------------------------------------------------------
module cla16_slice_mux
   import cla16_wide_add_seq_pkg::*;
#(
   parameter int WORDS = 4,
   parameter int IDX_W = 2
) (
   input  logic [SLICE_W*WORDS-1:0] vec,
   input  logic [IDX_W-1:0]         idx,
   output logic [SLICE_W-1:0]       slice
);

   logic [SLICE_W-1:0] parts_s [WORDS];

   for (genvar g = 0; g < WORDS; g++) begin : g_parts
      assign parts_s[g] = vec[g*SLICE_W +: SLICE_W];
   end

   // Slice select; index values past the last slice (non power-of-two WORDS) give zero.
   always_comb begin
      slice = {SLICE_W{1'b0}};
      if (int'(idx) < WORDS) begin
         slice = parts_s[idx];
      end else begin
         slice = {SLICE_W{1'b0}};
      end
   end

endmodule

// File: rtl/cla16_wide_add_seq.sv
// ---------------------------------------------------------------------------
// cla16_wide_add_seq
// Performs a WORDS*16-bit add or subtract by streaming 16-bit slices, LSB
// first, through an external combinational cla16 and rippling the carry
// between slices in a register. Subtraction is A + ~B + 1.
//   clk   in   clock, all state on the rising edge
//   rst   in   synchronous active-high reset (aborts any operation)
//   bus   slave modport of cla16_wide_add_seq_if:
//         in_*  operand request, add_* cla16 link, out_* result
// Accept at edge E -> out_valid high after edge E+WORDS; one operation per
// WORDS+2 cycles when the consumer is always ready.
// ---------------------------------------------------------------------------
module cla16_wide_add_seq
   import cla16_wide_add_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   cla16_wide_add_seq_if.slave   bus
);

   localparam int               IDX_W    = idx_width(WORDS);
   localparam int               OP_W     = SLICE_W * WORDS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e              state_r;
   state_e              state_nxt_s;
   logic                accept_s;
   logic                capture_s;
   logic                last_s;

   logic [OP_W-1:0]     a_r;
   logic [OP_W-1:0]     b_r;
   logic [OP_W-1:0]     sum_r;
   logic                cout_r;
   logic                carry_r;
   logic [IDX_W-1:0]    idx_r;
   logic [IDX_W-1:0]    nxt_idx_s;
   logic [SLICE_W-1:0]  add_a_r;
   logic [SLICE_W-1:0]  add_b_r;
   logic [SLICE_W-1:0]  a_slice_s;
   logic [SLICE_W-1:0]  b_slice_s;
   logic                in_ready_r;
   logic                out_valid_r;

   assign nxt_idx_s = idx_r + IDX_W'(1);

   // The slice fed to cla16 on the next cycle is looked up one index ahead so
   // add_a/add_b can come straight from flops during RUN.
   cla16_slice_mux #(.WORDS(WORDS), .IDX_W(IDX_W)) u_mux_a (
      .vec   (a_r),
      .idx   (nxt_idx_s),
      .slice (a_slice_s)
   );

   cla16_slice_mux #(.WORDS(WORDS), .IDX_W(IDX_W)) u_mux_b (
      .vec   (b_r),
      .idx   (nxt_idx_s),
      .slice (b_slice_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state and per-cycle control strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            capture_s = 1'b1;
            if (idx_r == LAST_IDX) begin
               last_s      = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Handshake flags registered from the next state so they are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt_s == ST_IDLE);
         out_valid_r <= (state_nxt_s == ST_DONE);
      end
   end

   // Operand latch, slice feed to cla16, carry ripple and result assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= {OP_W{1'b0}};
         b_r     <= {OP_W{1'b0}};
         sum_r   <= {OP_W{1'b0}};
         cout_r  <= 1'b0;
         carry_r <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
         add_a_r <= {SLICE_W{1'b0}};
         add_b_r <= {SLICE_W{1'b0}};
      end else if (accept_s) begin
         // B is stored pre-inverted for subtract; the +1 enters as carry-in.
         a_r     <= bus.in_a;
         b_r     <= bus.in_sub ? ~bus.in_b : bus.in_b;
         carry_r <= bus.in_sub ? 1'b1 : bus.in_cin;
         idx_r   <= {IDX_W{1'b0}};
         add_a_r <= bus.in_a[SLICE_W-1:0];
         add_b_r <= bus.in_sub ? ~bus.in_b[SLICE_W-1:0] : bus.in_b[SLICE_W-1:0];
      end else if (capture_s) begin
         for (int w = 0; w < WORDS; w++) begin
            if (idx_r == IDX_W'(w)) begin
               sum_r[w*SLICE_W +: SLICE_W] <= bus.add_sum;
            end
         end
         if (last_s) begin
            // Final carry goes to the result; the adder inputs return to zero.
            cout_r  <= bus.add_cout;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            add_a_r <= {SLICE_W{1'b0}};
            add_b_r <= {SLICE_W{1'b0}};
         end else begin
            carry_r <= bus.add_cout;
            idx_r   <= nxt_idx_s;
            add_a_r <= a_slice_s;
            add_b_r <= b_slice_s;
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = sum_r;
   assign bus.out_cout  = cout_r;
   assign bus.add_a     = add_a_r;
   assign bus.add_b     = add_b_r;
   assign bus.add_cin   = carry_r;

endmodule
